// File: rtl/dac_fifo_rd_ctrl.sv
// dac_fifo_rd_ctrl: read-side sequencer for the 4-lane DAC sample FIFO bank.
// Waits for the FIFO to prefill to PREFILL entries, then streams one sample
// per cycle to the DAC. An underflow mutes the output, bumps a saturating
// event counter and re-arms the prefill wait.
//
// Optional feature macro: DAC_CTRL_HOLD_LAST_EN
//   defined   -> dac_data holds the last valid sample while dac_valid=0
//   undefined -> dac_data is forced to zero while dac_valid=0
module dac_fifo_rd_ctrl #(
  parameter int DW      = 16,
  parameter int LANES   = 4,
  parameter int CNT_W   = 10,
  parameter int PREFILL = 256
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_rd_count,
  input  logic [LANES*DW-1:0]   fifo_dout,
  input  logic                  cnt_clr,
  output logic                  fifo_rd_en,
  output logic [LANES*DW-1:0]   dac_data,
  output logic                  dac_valid,
  output logic [1:0]            state,
  output logic                  underflow_pulse,
  output logic [15:0]           underflow_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_UFLOW   = 2'd3
  } state_e;

  // One extra bit so a PREFILL equal to the full count range still compares correctly.
  localparam logic [CNT_W:0] PREFILL_C = PREFILL[CNT_W:0];
  localparam logic [15:0]    CNT_MAX   = 16'hFFFF;

  state_e                state_q, state_d;
  logic                  rd_vld_q;
  logic                  dac_valid_q, dac_valid_d;
  logic [LANES*DW-1:0]   dac_data_q, dac_data_d;
  logic                  pulse_q, pulse_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  thresh_ok_s;
  logic                  rd_en_s;

  assign thresh_ok_s = ({1'b0, fifo_rd_count} >= PREFILL_C);

  // Read strobe: only in RUN, only while requested, never into an empty FIFO.
  assign rd_en_s = (state_q == ST_RUN) & enable & ~fifo_empty;

  // Next-state logic; disable wins over underflow in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PREFILL;
        else        state_d = ST_IDLE;
      end
      ST_PREFILL: begin
        if (!enable)          state_d = ST_IDLE;
        else if (thresh_ok_s) state_d = ST_RUN;
        else                  state_d = ST_PREFILL;
      end
      ST_RUN: begin
        if (!enable)         state_d = ST_IDLE;
        else if (fifo_empty) state_d = ST_UFLOW;
        else                 state_d = ST_RUN;
      end
      ST_UFLOW: begin
        if (enable) state_d = ST_PREFILL;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Underflow event detection and saturating counter; clear beats increment.
  always_comb begin
    pulse_d = (state_q == ST_RUN) && (state_d == ST_UFLOW);
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = 16'h0000;
    end else if (pulse_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output stage: a sample is real exactly when the read issued two cycles ago lands.
  always_comb begin
    dac_valid_d = rd_vld_q;
    dac_data_d  = dac_data_q;
    if (rd_vld_q) begin
      dac_data_d = fifo_dout;
    end else begin
`ifdef DAC_CTRL_HOLD_LAST_EN
      dac_data_d = dac_data_q;
`else
      dac_data_d = {(LANES*DW){1'b0}};
`endif
    end
  end

  // State, read-valid pipeline, DAC outputs and underflow bookkeeping registers.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      rd_vld_q    <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= {(LANES*DW){1'b0}};
      pulse_q     <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_en_s;
      dac_valid_q <= dac_valid_d;
      dac_data_q  <= dac_data_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fifo_rd_en      = rd_en_s;
  assign dac_data        = dac_data_q;
  assign dac_valid       = dac_valid_q;
  assign state           = state_q;
  assign underflow_pulse = pulse_q;
  assign underflow_cnt   = cnt_q;

endmodule

// File: tb/tb_dac_fifo_rd_ctrl.sv
// Testbench for dac_fifo_rd_ctrl: cycle model of the sequencer plus a
// scoreboard queue of samples read from a modelled FIFO.
module tb_dac_fifo_rd_ctrl;
  localparam int DW = 16, LANES = 4, CNT_W = 10, PREFILL = 256;
  localparam logic [1:0] S_IDLE = 2'd0, S_PRE = 2'd1, S_RUN = 2'd2, S_UF = 2'd3;

  logic                rd_clk = 1'b0;
  logic                rd_rst_n;
  logic                enable;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_rd_count;
  logic [LANES*DW-1:0] fifo_dout;
  logic                cnt_clr;
  logic                fifo_rd_en;
  logic [LANES*DW-1:0] dac_data;
  logic                dac_valid;
  logic [1:0]          state;
  logic                underflow_pulse;
  logic [15:0]         underflow_cnt;

  dac_fifo_rd_ctrl #(.DW(DW), .LANES(LANES), .CNT_W(CNT_W), .PREFILL(PREFILL)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_count(fifo_rd_count), .fifo_dout(fifo_dout), .cnt_clr(cnt_clr),
    .fifo_rd_en(fifo_rd_en), .dac_data(dac_data), .dac_valid(dac_valid), .state(state),
    .underflow_pulse(underflow_pulse), .underflow_cnt(underflow_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_rd = -1;
  int first_vld = -1;

  // Reference model state
  logic [1:0]          m_state;
  logic                m_vld1, m_valid, m_pulse;
  logic [15:0]         m_cnt;
  logic [LANES*DW-1:0] m_last;
  logic [LANES*DW-1:0] sb_q[$];
  logic [15:0]         data_ctr = 16'h0000;

  task automatic model_reset();
    m_state = S_IDLE; m_vld1 = 1'b0; m_valid = 1'b0; m_pulse = 1'b0;
    m_cnt = 16'h0000; m_last = '0; sb_q.delete();
  endtask

  // One clock cycle: inputs already set at the negedge; check, advance, return at next negedge.
  task automatic tick();
    logic                m_rd;
    logic [1:0]          ns;
    logic [15:0]         ncnt;
    logic [LANES*DW-1:0] exp_data;
    #1;
    m_rd = (m_state == S_RUN) && enable && !fifo_empty;
    total++;
    if (state !== m_state) begin bad++; $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, state, m_state); end
    total++;
    if (fifo_rd_en !== m_rd) begin bad++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, fifo_rd_en, m_rd); end
    total++;
    if (dac_valid !== m_valid) begin bad++; $display("FAIL dac_valid cyc=%0d got=%b exp=%b", cyc, dac_valid, m_valid); end
    total++;
    if (underflow_pulse !== m_pulse) begin bad++; $display("FAIL uf_pulse cyc=%0d got=%b exp=%b", cyc, underflow_pulse, m_pulse); end
    total++;
    if (underflow_cnt !== m_cnt) begin bad++; $display("FAIL uf_cnt cyc=%0d got=%h exp=%h", cyc, underflow_cnt, m_cnt); end
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty cyc=%0d got=%h exp=<queued sample>", cyc, dac_data);
        exp_data = m_last;
      end else begin
        exp_data = sb_q.pop_front();
        m_last = exp_data;
      end
    end else begin
`ifdef DAC_CTRL_HOLD_LAST_EN
      exp_data = m_last;
`else
      exp_data = '0;
`endif
    end
    total++;
    if (dac_data !== exp_data) begin bad++; $display("FAIL dac_data cyc=%0d got=%h exp=%h", cyc, dac_data, exp_data); end
    if (fifo_rd_en === 1'b1 && first_rd < 0) first_rd = cyc;
    if (dac_valid === 1'b1 && first_vld < 0) first_vld = cyc;

    case (m_state)
      S_IDLE:  ns = enable ? S_PRE : S_IDLE;
      S_PRE:   ns = !enable ? S_IDLE : ((int'(fifo_rd_count) >= PREFILL) ? S_RUN : S_PRE);
      S_RUN:   ns = !enable ? S_IDLE : (fifo_empty ? S_UF : S_RUN);
      default: ns = enable ? S_PRE : S_IDLE;
    endcase
    if (cnt_clr) ncnt = 16'h0000;
    else if (m_state == S_RUN && ns == S_UF && m_cnt != 16'hFFFF) ncnt = m_cnt + 16'h0001;
    else ncnt = m_cnt;

    @(posedge rd_clk);
    #1;
    m_pulse = (m_state == S_RUN) && (ns == S_UF);
    m_valid = m_vld1;
    m_vld1  = m_rd;
    m_state = ns;
    m_cnt   = ncnt;
    if (m_rd) begin
      data_ctr = data_ctr + 16'h0001;
      fifo_dout = {LANES{data_ctr}};
      sb_q.push_back(fifo_dout);
    end
    cyc++;
    @(negedge rd_clk);
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_rd_count = '0;
    fifo_dout = '0; cnt_clr = 1'b0;
    model_reset();
    @(negedge rd_clk);
    #1;
    total++;
    if (state !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++;
    if (fifo_rd_en !== 1'b0 || dac_valid !== 1'b0) begin bad++; $display("FAIL rst_ctl got=%b%b exp=00", fifo_rd_en, dac_valid); end
    total++;
    if (dac_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", dac_data); end
    total++;
    if (underflow_pulse !== 1'b0 || underflow_cnt !== 16'h0000) begin bad++; $display("FAIL rst_uf got=%b/%h exp=0/0", underflow_pulse, underflow_cnt); end
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_prefill();
    enable = 1'b1; fifo_empty = 1'b0;
    for (int c = 0; c <= 300; c++) begin
      fifo_rd_count = CNT_W'(c);
      tick();
    end
    total++;
    if (first_rd < 0 || (first_vld - first_rd) !== 2) begin
      bad++; $display("FAIL latency got=%0d exp=2 (first_rd=%0d)", first_vld - first_rd, first_rd);
    end
  endtask

  task automatic test_stream();
    fifo_rd_count = 10'd300;
    repeat (20) tick();
  endtask

  task automatic test_underflow();
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    total++;
    if (underflow_pulse !== 1'b1 || underflow_cnt !== 16'h0001 || state !== S_UF) begin
      bad++; $display("FAIL uf_entry got=%b/%h/%0d exp=1/0001/3", underflow_pulse, underflow_cnt, state);
    end
    repeat (10) tick();
  endtask

  task automatic test_stop_empty();
    enable = 1'b0; fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    total++;
    if (state !== S_IDLE || underflow_cnt !== 16'h0001) begin
      bad++; $display("FAIL stop_empty got=%0d/%h exp=0/0001", state, underflow_cnt);
    end
    repeat (5) tick();
  endtask

  task automatic test_saturate();
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    enable = 1'b1; fifo_empty = 1'b0; fifo_rd_count = 10'd300;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      fifo_empty = 1'b1;
      tick();
      fifo_empty = 1'b0;
      repeat (3) tick();
    end
    total++;
    if (underflow_cnt !== 16'hFFFF) begin bad++; $display("FAIL saturate got=%h exp=ffff", underflow_cnt); end
    fifo_empty = 1'b1; cnt_clr = 1'b1;
    tick();
    fifo_empty = 1'b0; cnt_clr = 1'b0;
    total++;
    if (underflow_cnt !== 16'h0000 || underflow_pulse !== 1'b1) begin
      bad++; $display("FAIL clr_vs_inc got=%h/%b exp=0000/1", underflow_cnt, underflow_pulse);
    end
    repeat (6) tick();
  endtask

  task automatic test_async_reset();
    enable = 1'b1; fifo_empty = 1'b0; fifo_rd_count = 10'd300;
    repeat (4) tick();
    #2;
    rd_rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || fifo_rd_en !== 1'b0 || dac_valid !== 1'b0) begin
      bad++; $display("FAIL async_ctl got=%0d/%b/%b exp=0/0/0", state, fifo_rd_en, dac_valid);
    end
    total++;
    if (dac_data !== '0 || underflow_cnt !== 16'h0000 || underflow_pulse !== 1'b0) begin
      bad++; $display("FAIL async_data got=%h/%h/%b exp=0/0/0", dac_data, underflow_cnt, underflow_pulse);
    end
    model_reset();
    @(negedge rd_clk);
    rd_rst_n = 1'b1; enable = 1'b0;
    tick();
    enable = 1'b1;
    repeat (8) tick();
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    repeat (8) tick();
    enable = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_stream();
    test_underflow();
    test_stop_empty();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_fifo_rd_ctrl.md
Name: dac_fifo_rd_ctrl

Overview:
Read-side sequencer for the 4-lane DAC sample FIFO bank, where all lanes share one rd_en and one empty flag. It waits for the FIFO to prefill to a threshold, then streams samples continuously to the DAC interface. On underflow it mutes the output, counts the event and re-arms the prefill. It replaces the free-running "read whenever not empty" logic on the rd_clk side.

Parameters:
DW, 16, sample width per lane
LANES, 4, number of lanes packed on fifo_dout / dac_data (lane 0 in LSBs)
CNT_W, 10, width of FIFO read-side data count
PREFILL, 256, minimum fifo_rd_count before streaming starts (0 allowed)

Ports:
rd_clk  in  1  read-domain clock; all logic on rising edge
rd_rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = stream requested, 0 = stop and mute
fifo_empty  in  1  empty flag from lane-0 FIFO (all lanes written and read in lockstep)
fifo_rd_count  in  CNT_W  FIFO read data count
fifo_dout  in  LANES*DW  FIFO read data; valid 1 cycle after fifo_rd_en (standard-mode FIFO)
cnt_clr  in  1  synchronous clear of underflow_cnt
fifo_rd_en  out  1  read strobe to all lane FIFOs
dac_data  out  LANES*DW  registered samples to DAC
dac_valid  out  1  dac_data carries a real sample
state  out  2  current FSM state (IDLE=0, PREFILL=1, RUN=2, UFLOW=3)
underflow_pulse  out  1  one-cycle pulse on underflow entry
underflow_cnt  out  16  saturating underflow event count

Behaviour:
- Reset (async, rd_rst_n=0) forces the following; release is synchronous to rd_clk:
  - state=IDLE; fifo_rd_en=0, dac_valid=0, dac_data=0
  - underflow_pulse=0, underflow_cnt=0, internal read-valid pipeline=0
- FSM, one transition per cycle:
  - IDLE: enable=1 -> PREFILL.
  - PREFILL: enable=0 -> IDLE; else fifo_rd_count>=PREFILL -> RUN. PREFILL=0 passes on the first PREFILL cycle.
  - RUN: enable=0 -> IDLE (takes priority); else fifo_empty=1 -> UFLOW.
  - UFLOW: always exactly one cycle; enable=1 -> PREFILL, else IDLE.
- fifo_rd_en = (state==RUN) & enable & ~fifo_empty, combinational. The FIFO is never read while empty, and never read outside RUN.
- Pipeline:
  - rd_vld_q <= fifo_rd_en.
  - Next edge: dac_valid <= rd_vld_q; dac_data <= rd_vld_q ? fifo_dout : 0.
  - Latency: fifo_rd_en high in cycle N -> dac_valid/dac_data in cycle N+2.
- In-flight reads still complete after leaving RUN. At most 1 sample after the last fifo_rd_en appears; no data is dropped or duplicated.
- dac_data is 0 whenever dac_valid=0 (mute).
- Underflow:
  - Entering UFLOW raises underflow_pulse for exactly one cycle.
  - The same cycle, underflow_cnt increments, saturating at 16'hFFFF.
  - enable=0 and fifo_empty=1 in the same RUN cycle -> IDLE; no underflow counted.
- cnt_clr=1 sets underflow_cnt=0 next cycle. If clear and increment coincide, clear wins (result 0); underflow_pulse still fires.
- enable toggling mid-PREFILL returns to IDLE. The next enable restarts the threshold check from the live count; no internal history is kept.
- All lanes share the read strobe; lanes 1..3 have no empty/full check.

Optional Feature:
DAC_CTRL_HOLD_LAST_EN:
- Defined: when dac_valid=0, dac_data holds the last valid sample instead of 0. Reset still loads 0.
- Undefined: mute-to-zero as above.
- dac_valid timing is identical in both builds.

Test Plan:
1. PREFILL=256, enable=1, fifo_rd_count ramps 0..300 with fifo_empty=0 -> state PREFILL until the count reaches 256, RUN the next cycle; first dac_valid 2 cycles after the first fifo_rd_en.
2. RUN with fifo_dout incrementing per read (0x0001.., all lanes) -> dac_data sequence contiguous, no gaps or repeats; dac_data=0 before the first dac_valid.
3. In RUN, fifo_empty=1 for 1 cycle -> fifo_rd_en=0 that cycle, underflow_pulse=1 for 1 cycle, underflow_cnt=1, state UFLOW then PREFILL; restreams once the count ≥ PREFILL.
4. In RUN, enable and fifo_empty both drop the same cycle -> state IDLE, underflow_cnt unchanged, last in-flight sample still output with dac_valid=1, then dac_valid=0, dac_data=0.
5. underflow_cnt preloaded to 0xFFFF via 65535 forced underflows (or forced state) plus one more -> stays 0xFFFF. cnt_clr coincident with an underflow -> 0.
6. Assert rd_rst_n=0 mid-RUN between clock edges -> all outputs 0 immediately (async). Deassert -> IDLE. With DAC_CTRL_HOLD_LAST_EN, a gap in RUN holds the last sample (e.g. 0x1234 per lane) while dac_valid=0.
